interleaved_fifo_ctrl: RTL and testbench

Synchronous FIFO controller that drives two single-port RAM banks, each with 2-cycle registered latency, as one FIFO: even entries live in bank 0, odd entries in bank 1. Each cycle one bank can be written while the other is read, so the FIFO sustains one push and one pop per cycle. The block sits between the producer/consumer valid-ready streams and the two RAM bank instances. A 4-entry output prefetch buffer hides the RAM read latency.

---
 rtl/interleaved_fifo_ctrl.sv | 126 ++++++++++++
 tb/tb_interleaved_fifo_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/interleaved_fifo_ctrl.sv
// Two-bank interleaved FIFO controller. Even entries live in bank 0 and odd
// entries in bank 1, so a push to one bank and a read of the other can share
// a cycle. A 4-entry prefetch buffer hides the 2-cycle RAM read latency.
module interleaved_fifo_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 512,
  parameter int BANK_DEPTH    = FIFO_DEPTH / 2,
  parameter int LB_BANK_DEPTH = $clog2(BANK_DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(FIFO_DEPTH+4):0]   count,
  output logic [DATA_WIDTH-1:0]           ram0_din,
  output logic [LB_BANK_DEPTH-1:0]        ram0_addr,
  output logic                            ram0_wr_en,
  input  logic [DATA_WIDTH-1:0]           ram0_dout,
  output logic [DATA_WIDTH-1:0]           ram1_din,
  output logic [LB_BANK_DEPTH-1:0]        ram1_addr,
  output logic                            ram1_wr_en,
  input  logic [DATA_WIDTH-1:0]           ram1_dout
);
  localparam int PW = LB_BANK_DEPTH + 1;          // pointer width
  localparam int AW = LB_BANK_DEPTH + 2;          // ram_avail width (0..FIFO_DEPTH)
  localparam int CW = $clog2(FIFO_DEPTH + 4) + 1; // count width

  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [AW-1:0]         ram_avail;
  logic [1:0]            inf_vld, inf_bank;       // in-flight read shift register
  logic [DATA_WIDTH-1:0] pbuf [4];
  logic [1:0]            head, tail;
  logic [2:0]            occ, inflight_cnt;
  logic                  read_issue, push, pop, cap;
  logic [DATA_WIDTH-1:0] cap_data;

  logic [1:0][LB_BANK_DEPTH-1:0] addr_q, addr_d;
  logic [1:0][DATA_WIDTH-1:0]    din_q, din_d;
  logic [1:0]                    we_d;

  // Reads are issued purely from registered state so the issue decision never
  // combinationally depends on the stream handshakes.
  assign inflight_cnt = {2'b0, inf_vld[0]} + {2'b0, inf_vld[1]};
  assign read_issue   = !rst && (ram_avail != '0) && ((occ + inflight_cnt) < 3'd4);
  // A same-bank collision gives the read priority; the push retries next cycle.
  assign in_ready     = !rst && (ram_avail < AW'(FIFO_DEPTH))
                        && !(read_issue && (rd_ptr[0] == wr_ptr[0]));
  assign push         = in_valid && in_ready;
  assign out_valid    = !rst && (occ != 3'd0);
  assign out_data     = pbuf[head];
  assign pop          = out_valid && out_ready;
  assign cap          = inf_vld[1];
  assign cap_data     = inf_bank[1] ? ram1_dout : ram0_dout;

  // Per-bank port steering: read, write, or hold the previous address/data.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      addr_d[b] = addr_q[b];
      din_d[b]  = din_q[b];
      we_d[b]   = 1'b0;
      if (rst) begin
        addr_d[b] = '0;
        din_d[b]  = '0;
      end else if (read_issue && (rd_ptr[0] == 1'(b))) begin
        addr_d[b] = rd_ptr[PW-1:1];
      end else if (push && (wr_ptr[0] == 1'(b))) begin
        addr_d[b] = wr_ptr[PW-1:1];
        din_d[b]  = in_data;
        we_d[b]   = 1'b1;
      end
    end
  end

  assign ram0_addr  = addr_d[0];
  assign ram0_din   = din_d[0];
  assign ram0_wr_en = we_d[0];
  assign ram1_addr  = addr_d[1];
  assign ram1_din   = din_d[1];
  assign ram1_wr_en = we_d[1];

  // Remember last bank address/data so idle banks see stable inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      addr_q <= addr_d;
      din_q  <= din_d;
    end
  end

  // Pointers, RAM occupancy, in-flight tracking, buffer indices and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_avail <= '0;
      inf_vld   <= '0;
      inf_bank  <= '0;
      head      <= '0;
      tail      <= '0;
      occ       <= '0;
      count     <= '0;
    end else begin
      if (push)       wr_ptr <= wr_ptr + PW'(1);
      if (read_issue) rd_ptr <= rd_ptr + PW'(1);
      ram_avail <= ram_avail + AW'(push) - AW'(read_issue);
      inf_vld   <= {inf_vld[0], read_issue};
      inf_bank  <= {inf_bank[0], rd_ptr[0]};
      if (cap) tail <= tail + 2'd1;
      if (pop) head <= head + 2'd1;
      occ   <= occ + 3'(cap) - 3'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Prefetch buffer storage; contents are don't-care until captured.
  always_ff @(posedge clk) begin
    if (cap) pbuf[tail] <= cap_data;
  end

endmodule

// File: tb/tb_interleaved_fifo_ctrl.sv
// Bench for interleaved_fifo_ctrl: behavioural 2-cycle RAM banks plus a queue
// scoreboard that tracks what the FIFO must hold and emit.
module tb_interleaved_fifo_ctrl;
  localparam int DW = 8;
  localparam int FD = 16;
  localparam int BD = FD / 2;
  localparam int LB = $clog2(BD);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [$clog2(FD+4):0] count;
  logic [DW-1:0] ram0_din, ram1_din, ram0_dout, ram1_dout;
  logic [LB-1:0] ram0_addr, ram1_addr;
  logic ram0_wr_en, ram1_wr_en;

  always #5 clk = ~clk;

  interleaved_fifo_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count),
    .ram0_din(ram0_din), .ram0_addr(ram0_addr), .ram0_wr_en(ram0_wr_en), .ram0_dout(ram0_dout),
    .ram1_din(ram1_din), .ram1_addr(ram1_addr), .ram1_wr_en(ram1_wr_en), .ram1_dout(ram1_dout)
  );

  // Single-port banks: address/write registered on entry, array read into an
  // output register one cycle later; writes commit one cycle after the strobe.
  logic [DW-1:0] mem0 [BD];
  logic [DW-1:0] mem1 [BD];
  logic [LB-1:0] a0_q, a1_q;
  logic [DW-1:0] d0_q, d1_q;
  logic w0_q, w1_q;
  always @(posedge clk) begin
    a0_q <= ram0_addr; d0_q <= ram0_din; w0_q <= ram0_wr_en;
    a1_q <= ram1_addr; d1_q <= ram1_din; w1_q <= ram1_wr_en;
    ram0_dout <= mem0[a0_q];
    ram1_dout <= mem1[a1_q];
    if (w0_q) mem0[a0_q] <= d0_q;
    if (w1_q) mem1[a1_q] <= d1_q;
  end

  int n_chk = 0, n_err = 0;
  logic [DW-1:0] q[$];
  int acc, stalls;
  logic last_ov, last_ir;
  int last_cnt;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One clock of stimulus; observes the handshake and updates the scoreboard.
  task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic ordy);
    logic ps, pp;
    @(negedge clk);
    in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    chk("count", int'(count), q.size());
    if (q.size() == 0) chk("ov_when_empty", int'(out_valid), 0);
    if (q.size() >= FD + 4) chk("ir_when_full", int'(in_ready), 0);
    ps = in_valid && in_ready;
    pp = out_valid && out_ready;
    last_ov = out_valid; last_ir = in_ready; last_cnt = int'(count);
    if (pp) begin
      if (q.size() == 0) chk("pop_empty", int'(out_valid), 0);
      else begin
        chk("order", int'(out_data), int'(q[0]));
        void'(q.pop_front());
      end
    end
    if (ps) begin q.push_back(d); acc++; end
    if (iv && !in_ready) stalls++;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_wr_en", int'({ram0_wr_en, ram1_wr_en}), 0);
      chk("rst_addr", int'({ram0_addr, ram1_addr}), 0);
      chk("rst_din", int'({ram0_din, ram1_din}), 0);
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    q.delete();
    #1;
    chk("ready_after_rst", int'(in_ready), 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() > 0; i++) cycle(1'b0, '0, 1'b1);
    chk("drain_done", q.size(), 0);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);
  endtask

  initial begin
    do_reset(3);

    // Fall-through: single push becomes visible 4 cycles later.
    cycle(1'b1, 8'hA5, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      cycle(1'b0, '0, 1'b1);
      chk($sformatf("ft_out_valid_t%0d", k), int'(last_ov), (k == 4) ? 1 : 0);
    end
    cycle(1'b0, '0, 1'b1);
    chk("ft_count_after_pop", last_cnt, 0);

    // Fill with no consumer: exactly FD+4 accepts.
    acc = 0;
    for (int i = 0; i < FD + 30; i++) cycle(1'b1, DW'(i + 8'h40), 1'b0);
    chk("fill_accepts", acc, FD + 4);
    cycle(1'b1, 8'h00, 1'b1);
    chk("fill_count", last_cnt, FD + 4);
    chk("full_push_refused", int'(last_ir), 0);
    drain();

    // Equal pointer parity: pop first, then push -> one conflict stall.
    for (int i = 0; i < 6; i++) cycle(1'b1, DW'(8'h80 + i), 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b0);
    stalls = 0;
    cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 30; i++) cycle(1'b1, DW'(8'h90 + i), 1'b1);
    chk("parity_stall", stalls, 1);
    drain();

    // Continuous stream across pointer wrap.
    stalls = 0; acc = 0;
    for (int i = 0; i < 3 * FD; i++) cycle(1'b1, DW'(i), 1'b1);
    chk("cont_stall_le1", int'(stalls <= 1), 1);
    chk("cont_accepts", int'(acc >= 3 * FD - 1), 1);
    drain();

    // Random traffic, 50% each side.
    for (int i = 0; i < 600; i++)
      cycle(1'(($urandom % 2)), DW'($urandom), 1'(($urandom % 2)));
    drain();

    // Reset with data held and reads in flight.
    acc = 0;
    for (int i = 0; i < 40 && acc < 10; i++) cycle(1'b1, DW'(8'hC0 + i), 1'b0);
    chk("pre_rst_held", acc, 10);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    do_reset(2);
    for (int i = 0; i < 3; i++) cycle(1'b1, DW'(8'h3C + i), 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
